// File: rtl/itran_4x4.sv
// rtl/itran_4x4.sv - inverse 4x4 integer transform, two-stage valid/ready pipeline
// Purpose: reconstructs 16 signed residuals from 16 dequantised coefficients.
//   Stage 1 registers the row (horizontal) inverse pass. Stage 2 runs the column
//   (vertical) inverse pass, optional (x+32)>>>6 rounding and saturation, then
//   registers the residuals.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   enable                global advance enable, low freezes every register
//   in_valid, in_ready    input block handshake (in_ready = advance condition)
//   coeffs[15:0]          signed coefficients, index 4*row+col
//   out_valid, out_ready  output block handshake
//   residuals[15:0]       signed saturated residuals, index 4*row+col
//   sat                   at least one residual of the current output block clipped
module itran_4x4 #(
  parameter int IN_MSB  = 15,
  parameter int OUT_MSB = 8,
  parameter int ROUND   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_MSB:0]  coeffs    [15:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_MSB:0] residuals [15:0],
  output logic             sat
);

  // Each 1-D pass grows the dynamic range by at most 3.5x, so two bits per pass.
  localparam int W1 = IN_MSB + 3;
  localparam int W2 = IN_MSB + 5;

  localparam logic signed [W2-1:0] RND  = W2'(32);
  localparam logic signed [W2-1:0] YMAX = W2'((1 << OUT_MSB) - 1);
  localparam logic signed [W2-1:0] YMIN = ~YMAX;

  // 1-D inverse kernel, results packed as {f3,f2,f1,f0}.
  function automatic logic [4*W1-1:0] kern1(input logic signed [W1-1:0] a0, a1, a2, a3);
    logic signed [W1-1:0] e0, e1, e2, e3;
    e0 = a0 + a2;
    e1 = a0 - a2;
    e2 = (a1 >>> 1) - a3;
    e3 = a1 + (a3 >>> 1);
    return {e0 - e3, e1 - e2, e1 + e2, e0 + e3};
  endfunction

  function automatic logic [4*W2-1:0] kern2(input logic signed [W2-1:0] a0, a1, a2, a3);
    logic signed [W2-1:0] e0, e1, e2, e3;
    e0 = a0 + a2;
    e1 = a0 - a2;
    e2 = (a1 >>> 1) - a3;
    e3 = a1 + (a3 >>> 1);
    return {e0 - e3, e1 - e2, e1 + e2, e0 + e3};
  endfunction

  logic                    adv;
  logic                    s1_valid;
  logic signed [W1-1:0]    h_d  [15:0];
  logic signed [W1-1:0]    h_q  [15:0];
  logic signed [W2-1:0]    v_d  [15:0];
  logic [OUT_MSB:0]        r_d  [15:0];
  logic [15:0]             clip;

  assign adv      = enable && (!out_valid || out_ready);
  assign in_ready = adv;

  // Row pass: h[4r+k] = fk of coeffs[4r..4r+3].
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [4*W1-1:0] f;
    assign f = kern1(W1'($signed(coeffs[4*r])),   W1'($signed(coeffs[4*r+1])),
                     W1'($signed(coeffs[4*r+2])), W1'($signed(coeffs[4*r+3])));
    for (genvar k = 0; k < 4; k++) begin : g_k
      assign h_d[4*r+k] = $signed(f[k*W1 +: W1]);
    end
  end

  // Column pass: v[4k+c] = fk of h[c], h[4+c], h[8+c], h[12+c].
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [4*W2-1:0] f;
    assign f = kern2(W2'(h_q[c]), W2'(h_q[4+c]), W2'(h_q[8+c]), W2'(h_q[12+c]));
    for (genvar k = 0; k < 4; k++) begin : g_k
      assign v_d[4*k+c] = $signed(f[k*W2 +: W2]);
    end
  end

  // Rounding and saturation per residual.
  for (genvar i = 0; i < 16; i++) begin : g_out
    logic signed [W2-1:0] y;
    logic                 hi, lo;
    assign y       = (ROUND != 0) ? ((v_d[i] + RND) >>> 6) : v_d[i];
    assign hi      = y > YMAX;
    assign lo      = y < YMIN;
    assign clip[i] = hi || lo;
    assign r_d[i]  = hi ? YMAX[OUT_MSB:0] : (lo ? YMIN[OUT_MSB:0] : y[OUT_MSB:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      h_q       <= '{default: '0};
      residuals <= '{default: '0};
    end else if (adv) begin
      // Data registers advance even for bubbles; out_valid qualifies them.
      s1_valid  <= in_valid;
      h_q       <= h_d;
      out_valid <= s1_valid;
      residuals <= r_d;
      sat       <= |clip;
    end
  end

endmodule

// File: tb/tb_itran_4x4.sv
// tb/tb_itran_4x4.sv - scoreboard testbench for itran_4x4
module tb_itran_4x4;

  typedef int blk_t [16];
  typedef struct {
    blk_t r;
    bit   s;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, enable, in_valid, in_ready, out_valid, out_ready, sat;
  logic [15:0] coeffs    [15:0];
  logic [8:0]  residuals [15:0];

  always #5 clk = ~clk;

  itran_4x4 #(.IN_MSB(15), .OUT_MSB(8), .ROUND(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .coeffs(coeffs),
    .out_valid(out_valid), .out_ready(out_ready),
    .residuals(residuals), .sat(sat)
  );

  exp_t       sbq [$];
  exp_t       cur_exp;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] prev_res [15:0];
  bit         hold_prev = 1'b0;
  int         blk_no = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic blk_t fill(input int x);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = x;
    return b;
  endfunction

  // Every row equals {p0,p1,p2,p3}.
  function automatic blk_t rows(input int p0, p1, p2, p3);
    blk_t b;
    for (int r = 0; r < 4; r++) begin
      b[4*r] = p0; b[4*r+1] = p1; b[4*r+2] = p2; b[4*r+3] = p3;
    end
    return b;
  endfunction

  // Row k is filled with pk.
  function automatic blk_t cols(input int p0, p1, p2, p3);
    blk_t b;
    for (int c = 0; c < 4; c++) begin
      b[c] = p0; b[4+c] = p1; b[8+c] = p2; b[12+c] = p3;
    end
    return b;
  endfunction

  // Monitor/scoreboard: decisions taken at the falling edge hold through the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    int   bad;
    int   got;
    int   diff;
    if (!reset) begin
      if (hold_prev) begin
        diff = 0;
        for (int i = 0; i < 16; i++) if (residuals[i] !== prev_res[i]) diff++;
        chk("stall_residuals_changed", diff, 0);
        chk("stall_out_valid", int'(out_valid), 1);
      end
      if (out_valid && out_ready && enable) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output_queue_size", sbq.size(), 1);
        end else begin
          e   = sbq.pop_front();
          bad = -1;
          got = 0;
          for (int i = 0; i < 16; i++) begin
            if (bad < 0 && int'($signed(residuals[i])) != e.r[i]) begin
              bad = i;
              got = int'($signed(residuals[i]));
            end
          end
          checks++;
          if (bad >= 0) begin
            errors++;
            $display("FAIL residuals out_block %0d idx %0d: got %0d, expected %0d",
                     blk_no, bad, got, e.r[bad]);
          end
          chk($sformatf("sat out_block %0d", blk_no), int'(sat), int'(e.s));
          blk_no++;
        end
      end
      hold_prev = out_valid && !(out_ready && enable);
      prev_res  = residuals;
      if (in_valid && in_ready) sbq.push_back(cur_exp);
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic load(input int ia, input int va, input int ib, input int vb,
                      input blk_t e, input bit s);
    for (int i = 0; i < 16; i++) coeffs[i] = '0;
    coeffs[ia] = 16'(va);
    if (ib >= 0) coeffs[ib] = 16'(vb);
    cur_exp.r = e;
    cur_exp.s = s;
    in_valid  = 1'b1;
  endtask

  task automatic send(input int ia, input int va, input int ib, input int vb,
                      input blk_t e, input bit s);
    bit ok;
    load(ia, va, ib, vb, e, s);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready && !reset;
    end
    if (!ok) chk("in_ready_timeout", int'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  // Single block into an empty pipeline; out_valid must rise on the second edge.
  task automatic send_lat(input int ia, input int va, input blk_t e, input bit s);
    load(ia, va, -1, 0, e, s);
    @(negedge clk);
    chk("lat_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_out_valid_edge1", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_out_valid_edge2", int'(out_valid), 1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int n = 0; n < 50 && !empty; n++) begin
      @(negedge clk);
      empty = (sbq.size() == 0);
    end
    if (!empty) chk("drain_timeout_queue_size", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic stall_cycles(input bit use_enable, input int n);
    if (use_enable) enable = 1'b0;
    else            out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk(use_enable ? "en_stall_in_ready" : "bp_stall_in_ready", int'(in_ready), 0);
      chk(use_enable ? "en_stall_out_valid" : "bp_stall_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    enable    = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 16; i++) if (residuals[i] !== 9'd0) nz++;
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_sat"}, int'(sat), 0);
    chk({tag, "_nonzero_residuals"}, nz, 0);
  endtask

  initial begin
    blk_t mix;
    // coeffs[0]=64 plus coeffs[5]=64, rounded by hand.
    mix = '{2, 2, 1, 0,  2, 1, 1, 1,  1, 1, 1, 2,  0, 1, 2, 2};

    reset     = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) coeffs[i] = '0;
    cur_exp.r = fill(0);
    cur_exp.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    chk("reset_in_ready", int'(in_ready), 1);
    reset = 1'b0;

    send_lat(0, 0, fill(0), 1'b0);
    drain();
    send_lat(0, 64, fill(1), 1'b0);
    drain();

    // Back-to-back stream with out_ready held high.
    send(1, 64, -1, 0, rows(1, 1, 0, -1), 1'b0);
    send(2, 64, -1, 0, rows(1, -1, -1, 1), 1'b0);
    send(3, 64, -1, 0, rows(1, -1, 1, 0), 1'b0);
    send(4, 64, -1, 0, cols(1, 1, 0, -1), 1'b0);
    send(0, 64, 5, 64, mix, 1'b0);
    send(0, 32767, -1, 0, fill(255), 1'b1);
    send(0, -32768, -1, 0, fill(-256), 1'b1);
    send(0, 31, -1, 0, fill(0), 1'b0);
    send(0, 32, -1, 0, fill(1), 1'b0);
    send(0, -33, -1, 0, fill(-1), 1'b0);
    send(0, -32, -1, 0, fill(0), 1'b0);
    send(0, 16320, -1, 0, fill(255), 1'b0);
    send(0, 16352, -1, 0, fill(255), 1'b1);
    send(0, -16384, -1, 0, fill(-256), 1'b0);
    send(0, -16417, -1, 0, fill(-256), 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for 3 cycles with the 4th block waiting.
    send(0, 128, -1, 0, fill(2), 1'b0);
    send(4, 64, -1, 0, cols(1, 1, 0, -1), 1'b0);
    send(0, -192, -1, 0, fill(-3), 1'b0);
    load(3, 64, -1, 0, rows(1, -1, 1, 0), 1'b0);
    stall_cycles(1'b0, 3);
    send(3, 64, -1, 0, rows(1, -1, 1, 0), 1'b0);
    in_valid = 1'b0;
    drain();

    // Same stream shape frozen by enable for 2 cycles.
    send(0, 320, -1, 0, fill(5), 1'b0);
    send(2, 64, -1, 0, rows(1, -1, -1, 1), 1'b0);
    send(0, 448, -1, 0, fill(7), 1'b0);
    load(0, 64, 5, 64, mix, 1'b0);
    stall_cycles(1'b1, 2);
    send(0, 64, 5, 64, mix, 1'b0);
    in_valid = 1'b0;
    drain();

    // Reset with two blocks in flight discards both.
    send(0, 32767, -1, 0, fill(255), 1'b1);
    send(0, -192, -1, 0, fill(-3), 1'b0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_cleared("flush");
    sbq.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    send_lat(1, 64, rows(1, 1, 0, -1), 1'b0);
    drain();

    chk("final_queue_size", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
